// File: rtl/barrel_shifter_pkg.sv
// Shared constants for the barrel shifter: shift-type codes and amount-source encoding.
package barrel_shifter_pkg;

    localparam int DATA_W = 32;
    localparam int NUM_W  = 8;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // io_Shift_OP[0]: where the shift amount comes from
    localparam logic AMT_REG = 1'b1;
    localparam logic AMT_IMM = 1'b0;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with carry-out.
module barrel_shifter
    import barrel_shifter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        io_Shift_OP,
    input  logic [DATA_W-1:0] io_Shift_Data,
    input  logic [NUM_W-1:0]  io_Shift_Num,
    input  logic              io_Carry_Flag,
    output logic [DATA_W-1:0] io_Shift_Out,
    output logic              io_Shift_Carry_Out
);

    shift_type_e              shift_type;
    logic                     imm_mode;
    logic [NUM_W-1:0]         eff_n;
    logic [4:0]               amt;
    logic                     big;
    logic                     is32;
    logic [DATA_W:0]          lsl_ext;
    logic [DATA_W:0]          lsr_ext;
    logic signed [DATA_W:0]   asr_ext;
    logic [2*DATA_W-1:0]      ror_ext;
    logic [15:0]              dbg_reg_ops;

    assign shift_type = shift_type_e'(io_Shift_OP[2:1]);
    assign imm_mode   = (io_Shift_OP[0] == AMT_IMM);
    assign eff_n      = imm_mode ? {3'b000, io_Shift_Num[4:0]} : io_Shift_Num;
    assign amt        = eff_n[4:0];
    assign big        = |eff_n[7:5];
    assign is32       = (eff_n == 8'd32);

    // One extra bit on the exit side of each shift captures the last bit shifted out
    assign lsl_ext = {1'b0, io_Shift_Data} << amt;
    assign lsr_ext = {io_Shift_Data, 1'b0} >> amt;
    assign asr_ext = $signed({io_Shift_Data, 1'b0}) >>> amt;
    assign ror_ext = {io_Shift_Data, io_Shift_Data} >> amt;

    always_comb begin
        io_Shift_Out       = io_Shift_Data;
        io_Shift_Carry_Out = io_Carry_Flag;
        if (imm_mode && (amt == 5'd0)) begin
            // Immediate #0 encodes LSR/ASR #32 and RRX; LSL #0 passes through
            case (shift_type)
                SH_LSR: begin
                    io_Shift_Out       = '0;
                    io_Shift_Carry_Out = io_Shift_Data[DATA_W-1];
                end
                SH_ASR: begin
                    io_Shift_Out       = {DATA_W{io_Shift_Data[DATA_W-1]}};
                    io_Shift_Carry_Out = io_Shift_Data[DATA_W-1];
                end
                SH_ROR: begin
                    io_Shift_Out       = {io_Carry_Flag, io_Shift_Data[DATA_W-1:1]};
                    io_Shift_Carry_Out = io_Shift_Data[0];
                end
                default: ;
            endcase
        end else if (eff_n != '0) begin
            case (shift_type)
                SH_LSL: begin
                    if (big) begin
                        io_Shift_Out       = '0;
                        io_Shift_Carry_Out = is32 ? io_Shift_Data[0] : 1'b0;
                    end else begin
                        io_Shift_Out       = lsl_ext[DATA_W-1:0];
                        io_Shift_Carry_Out = lsl_ext[DATA_W];
                    end
                end
                SH_LSR: begin
                    if (big) begin
                        io_Shift_Out       = '0;
                        io_Shift_Carry_Out = is32 ? io_Shift_Data[DATA_W-1] : 1'b0;
                    end else begin
                        io_Shift_Out       = lsr_ext[DATA_W:1];
                        io_Shift_Carry_Out = lsr_ext[0];
                    end
                end
                SH_ASR: begin
                    if (big) begin
                        io_Shift_Out       = {DATA_W{io_Shift_Data[DATA_W-1]}};
                        io_Shift_Carry_Out = io_Shift_Data[DATA_W-1];
                    end else begin
                        io_Shift_Out       = asr_ext[DATA_W:1];
                        io_Shift_Carry_Out = asr_ext[0];
                    end
                end
                default: begin
                    // Register ROR by a nonzero multiple of 32 leaves data intact
                    if (amt == 5'd0) begin
                        io_Shift_Carry_Out = io_Shift_Data[DATA_W-1];
                    end else begin
                        io_Shift_Out       = ror_ext[DATA_W-1:0];
                        io_Shift_Carry_Out = ror_ext[DATA_W-1];
                    end
                end
            endcase
        end
    end

    // Debug-only count of register-amount operations; never feeds the datapath
    always_ff @(posedge clock) begin
        if (!reset) begin
            dbg_reg_ops <= '0;
        end else if (io_Shift_OP[0] == AMT_REG) begin
            dbg_reg_ops <= dbg_reg_ops + 16'd1;
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed vector table, boundary sweep, random stimulus.
module tb_barrel_shifter;

    logic        clock;
    logic        reset;
    logic [2:0]  io_Shift_OP;
    logic [31:0] io_Shift_Data;
    logic [7:0]  io_Shift_Num;
    logic        io_Carry_Flag;
    logic [31:0] io_Shift_Out;
    logic        io_Shift_Carry_Out;

    int checks = 0;
    int errors = 0;

    barrel_shifter dut (
        .clock              (clock),
        .reset              (reset),
        .io_Shift_OP        (io_Shift_OP),
        .io_Shift_Data      (io_Shift_Data),
        .io_Shift_Num       (io_Shift_Num),
        .io_Carry_Flag      (io_Carry_Flag),
        .io_Shift_Out       (io_Shift_Out),
        .io_Shift_Carry_Out (io_Shift_Carry_Out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] data;
        logic [7:0]  num;
        logic        c;
        logic [31:0] exp_out;
        logic        exp_c;
    } vec_t;

    vec_t vecs[$];

    // Bit-level reference built straight from the shift definitions
    function automatic void ref_shift(input logic [2:0] op, input logic [31:0] d,
                                      input logic [7:0] num, input logic c,
                                      output logic [31:0] o, output logic co);
        int n;
        int t;
        int r;
        t  = int'(op[2:1]);
        n  = op[0] ? int'(num) : (int'(num) % 32);
        o  = d;
        co = c;
        if (!op[0] && n == 0) begin
            if (t == 1) begin
                o = 32'h0; co = d[31];
            end else if (t == 2) begin
                for (int i = 0; i < 32; i++) o[i] = d[31];
                co = d[31];
            end else if (t == 3) begin
                for (int i = 0; i < 31; i++) o[i] = d[i+1];
                o[31] = c;
                co = d[0];
            end
        end else if (n != 0) begin
            case (t)
                0: begin
                    for (int i = 0; i < 32; i++) begin
                        o[i] = 1'b0;
                        if (i - n >= 0) o[i] = d[i-n];
                    end
                    co = 1'b0;
                    if (n <= 32) co = d[32-n];
                end
                1: begin
                    for (int i = 0; i < 32; i++) begin
                        o[i] = 1'b0;
                        if (i + n <= 31) o[i] = d[i+n];
                    end
                    co = 1'b0;
                    if (n <= 32) co = d[n-1];
                end
                2: begin
                    for (int i = 0; i < 32; i++) begin
                        o[i] = d[31];
                        if (i + n <= 31) o[i] = d[i+n];
                    end
                    co = d[31];
                    if (n <= 32) co = d[n-1];
                end
                default: begin
                    r = n % 32;
                    if (r == 0) begin
                        co = d[31];
                    end else begin
                        for (int i = 0; i < 32; i++) o[i] = d[(i+r)%32];
                        co = o[31];
                    end
                end
            endcase
        end
    endfunction

    task automatic check(input string name, input logic [31:0] exp_o, input logic exp_c);
        checks++;
        if (io_Shift_Out !== exp_o || io_Shift_Carry_Out !== exp_c) begin
            errors++;
            $display("FAIL %s: op=%b data=%h n=%0d c=%b got %h/%b expected %h/%b",
                     name, io_Shift_OP, io_Shift_Data, io_Shift_Num, io_Carry_Flag,
                     io_Shift_Out, io_Shift_Carry_Out, exp_o, exp_c);
        end
    endtask

    task automatic apply(input logic [2:0] op, input logic [31:0] d, input logic [7:0] n,
                         input logic c);
        @(negedge clock);
        io_Shift_OP   = op;
        io_Shift_Data = d;
        io_Shift_Num  = n;
        io_Carry_Flag = c;
        #1;
    endtask

    task automatic apply_ref(input string name, input logic [2:0] op, input logic [31:0] d,
                             input logic [7:0] n, input logic c);
        logic [31:0] eo;
        logic        ec;
        apply(op, d, n, c);
        ref_shift(op, d, n, c, eo, ec);
        check(name, eo, ec);
    endtask

    // Hold inputs, pulse reset across clock edges, and confirm outputs stay put
    task automatic reset_hold_check(input logic [2:0] op, input logic [31:0] d,
                                    input logic [7:0] n, input logic c);
        logic [31:0] eo;
        logic        ec;
        apply(op, d, n, c);
        ref_shift(op, d, n, c, eo, ec);
        check("pre_reset", eo, ec);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("during_reset", eo, ec);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("after_reset", eo, ec);
    endtask

    localparam logic [7:0] SWEEP_N [6] = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd255};

    initial begin
        reset         = 1'b0;
        io_Shift_OP   = 3'b000;
        io_Shift_Data = 32'h0;
        io_Shift_Num  = 8'h0;
        io_Carry_Flag = 1'b0;

        vecs.push_back('{"lsl_reg_n0",   3'b001, 32'h12345678, 8'd0,   1'b0, 32'h12345678, 1'b0});
        vecs.push_back('{"lsl_reg_n4",   3'b001, 32'h12345678, 8'd4,   1'b0, 32'h23456780, 1'b1});
        vecs.push_back('{"lsl_reg_n100", 3'b001, 32'h12345678, 8'd100, 1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{"lsl_imm_n0",   3'b000, 32'h12345678, 8'd0,   1'b0, 32'h12345678, 1'b0});
        vecs.push_back('{"lsr_reg_n4",   3'b011, 32'h12345678, 8'd4,   1'b0, 32'h01234567, 1'b1});
        vecs.push_back('{"lsr_reg_n100", 3'b011, 32'h12345678, 8'd100, 1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{"lsr_imm_32",   3'b010, 32'h12345678, 8'd0,   1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{"lsr_imm_32b",  3'b010, 32'h80000000, 8'd0,   1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{"asr_reg_n8",   3'b101, 32'h12345678, 8'd8,   1'b0, 32'h00123456, 1'b0});
        vecs.push_back('{"asr_reg_neg4", 3'b101, 32'h80000000, 8'd4,   1'b0, 32'hF8000000, 1'b0});
        vecs.push_back('{"asr_reg_n100", 3'b101, 32'h80000000, 8'd100, 1'b0, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{"asr_imm_32",   3'b100, 32'h80000000, 8'd0,   1'b0, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{"ror_reg_n4",   3'b111, 32'h12345678, 8'd4,   1'b0, 32'h81234567, 1'b1});
        vecs.push_back('{"ror_reg_n100", 3'b111, 32'h12345678, 8'd100, 1'b0, 32'h81234567, 1'b1});
        vecs.push_back('{"ror_reg_n0c1", 3'b111, 32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1});
        vecs.push_back('{"ror_reg_n0c0", 3'b111, 32'h12345678, 8'd0,   1'b0, 32'h12345678, 1'b0});
        vecs.push_back('{"ror_reg_n64",  3'b111, 32'h92345678, 8'd64,  1'b0, 32'h92345678, 1'b1});
        vecs.push_back('{"rrx",          3'b110, 32'h00000001, 8'd0,   1'b1, 32'h80000000, 1'b1});
        vecs.push_back('{"imm_ignore_hi",3'b000, 32'h12345678, 8'hE4,  1'b0, 32'h23456780, 1'b1});
        vecs.push_back('{"lsl_reg_n32",  3'b001, 32'h00000001, 8'd32,  1'b0, 32'h00000000, 1'b1});

        // Outputs must follow inputs even while reset is held low
        apply(3'b001, 32'h12345678, 8'd4, 1'b0);
        check("in_reset_lsl4", 32'h23456780, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        check("in_reset_hold", 32'h23456780, 1'b1);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].data, vecs[i].num, vecs[i].c);
            check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_c);
        end

        for (int t = 0; t < 4; t++) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 6; k++) begin
                    for (int c = 0; c < 2; c++) begin
                        for (int r = 0; r < 2; r++) begin
                            logic [2:0]  op;
                            logic [31:0] d;
                            op = {t[1:0], m[0]};
                            d  = (r == 0) ? ($urandom() | 32'h80000001) : $urandom();
                            apply_ref("sweep", op, d, SWEEP_N[k], c[0]);
                        end
                    end
                end
                if (t == 2 && m == 0) begin
                    reset_hold_check(3'b101, 32'h8000F00F, 8'd33, 1'b0);
                    reset_hold_check(3'b110, $urandom(), 8'd0, 1'b1);
                end
            end
        end

        for (int i = 0; i < 400; i++) begin
            logic [7:0] n;
            n = (i % 2 == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom());
            apply_ref("random", 3'($urandom()), $urandom(), n, 1'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_shifter.md
BARREL_SHIFTER -- requirements
Module: barrel_shifter

Interface
REQ-001 The block SHALL expose `clock`, input, 1 bit: the single clock; the block uses no other clock.
REQ-002 The block SHALL expose `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL expose `io_Shift_OP`, input, 3 bits: [2:1] shift type (00 LSL, 01 LSR, 10 ASR, 11 ROR); [0] amount source (1 = register amount, 0 = immediate amount).
REQ-004 The block SHALL expose `io_Shift_Data`, input, 32 bits: operand to be shifted.
REQ-005 The block SHALL expose `io_Shift_Num`, input, 8 bits: shift amount n, unsigned.
REQ-006 The block SHALL expose `io_Carry_Flag`, input, 1 bit: current C flag, written C below.
REQ-007 The block SHALL expose `io_Shift_Out`, output, 32 bits: shifted result.
REQ-008 The block SHALL expose `io_Shift_Carry_Out`, output, 1 bit: shifter carry-out.

Function
REQ-009 Outputs SHALL be purely combinational from the inputs, with zero-cycle latency and no internal state.
REQ-010 Register mode (OP[0]=1) SHALL use all 8 bits of n.
REQ-011 Immediate mode (OP[0]=0) SHALL use n[4:0] only; n[7:5] are ignored.
REQ-012 Any shift type with effective n=0 SHALL give Out=Data and Carry=C, except for the immediate-mode cases in REQ-017 and REQ-018.
REQ-013 LSL SHALL give:
  - n=1..31: Out = Data<<n, Carry = Data[32-n];
  - n=32: Out=0, Carry=Data[0];
  - n>32: Out=0, Carry=0.
REQ-014 LSR SHALL give:
  - n=1..31: Out = Data>>n (zero-fill), Carry = Data[n-1];
  - n=32: Out=0, Carry=Data[31];
  - n>32: Out=0, Carry=0.
REQ-015 ASR SHALL give:
  - n=1..31: Out = Data>>n (sign-fill), Carry = Data[n-1];
  - n>=32: all Out bits = Data[31], Carry = Data[31].
REQ-016 ROR SHALL give:
  - let r = n[4:0]; when r≠0: Out = Data rotated right by r, Carry = Out[31];
  - when r=0 and n≠0: Out=Data, Carry=Data[31].
REQ-017 Immediate LSR and immediate ASR with n[4:0]=0 SHALL behave as a shift by 32.
REQ-018 Immediate ROR with n[4:0]=0 SHALL perform RRX: Out = {C, Data[31:1]}, Carry = Data[0].
REQ-019 Immediate LSL with n[4:0]=0 SHALL follow REQ-012.

Reset
REQ-020 `reset` SHALL have no effect on `io_Shift_Out` or `io_Shift_Carry_Out`; outputs always reflect the current inputs, including while reset is low.
REQ-021 Any register added later (for example debug) SHALL clear synchronously when `reset`=0.

Structure
REQ-022 Shift-type codes (LSL/LSR/ASR/ROR) and the OP[0] mode meaning SHALL be defined as constants in shared package barrel_shifter_pkg.
REQ-023 The design SHALL be a single module with no sub-module.
REQ-024 Shift and rotate SHALL be built from log2 stages (1, 2, 4, 8, 16) or equivalent operators, plus explicit >=32 handling.

Verification
REQ-025 LSL, Data=0x12345678, C=0:
  - OP=001, n=0 -> 0x12345678 / C=0;
  - OP=001, n=4 -> 0x23456780 / 1;
  - OP=001, n=100 -> 0 / 0;
  - OP=000, n=0 -> 0x12345678 / 0.
REQ-026 LSR, Data=0x12345678, C=0:
  - OP=011, n=4 -> 0x01234567 / 1;
  - OP=011, n=100 -> 0 / 0;
  - OP=010, n=0 -> 0 / 0 (LSR #32, Carry=Data[31]=0).
REQ-027 ASR:
  - OP=101, Data=0x12345678, n=8 -> 0x00123456 / 0;
  - OP=101, Data=0x80000000, n=4 -> 0xF8000000 / 0;
  - OP=101, Data=0x80000000, n=100 -> 0xFFFFFFFF / 1.
REQ-028 ROR, Data=0x12345678:
  - OP=111, n=4 -> 0x81234567 / 1;
  - OP=111, n=100 -> 0x81234567 / 1;
  - OP=111, n=0 -> 0x12345678 / C.
REQ-029 RRX: OP=110, n=0, Data=0x00000001, C=1 -> 0x80000000 / 1.
REQ-030 Boundary sweep for all four types, both modes:
  - n in {0, 1, 31, 32, 33, 255}, random Data, both C values;
  - compare against a reference model;
  - toggle `reset` mid-sweep and confirm the outputs do not change.
